// File: rtl/csa_accum.sv
// Streaming multi-operand accumulator: folds one operand per beat into a carry-save
// sum/carry pair, then resolves it with a single carry-propagate add on the packet's last beat.
// Optional unsigned overflow flag (port out_ovf) when CSA_ACC_OVF_EN is defined.
`timescale 1ns/1ps

module csa_accum #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef CSA_ACC_OVF_EN
  ,
  output logic             out_ovf
`endif
);

  typedef enum logic [1:0] {
    ACC     = 2'd0,
    RESOLVE = 2'd1,
    OUT     = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] s_reg, c_reg;
  logic [WIDTH-1:0] csa_sum, csa_carry;
  logic             beat_acc;
  logic             out_hs;

  assign beat_acc = in_valid & in_ready;
  assign out_hs   = out_valid & out_ready;

  // 3:2 compressor; the carry word is pre-shifted so its top carry falls off the end.
  assign csa_sum   = s_reg ^ c_reg ^ in_data;
  assign csa_carry = ((s_reg & c_reg) | (s_reg & in_data) | (c_reg & in_data)) << 1;

`ifdef CSA_ACC_OVF_EN
  logic             drop;
  logic             csa_top;
  logic [WIDTH:0]   res_full;

  assign csa_top  = (s_reg[WIDTH-1] & c_reg[WIDTH-1]) | (s_reg[WIDTH-1] & in_data[WIDTH-1]) |
                    (c_reg[WIDTH-1] & in_data[WIDTH-1]);
  assign res_full = {1'b0, s_reg} + {1'b0, c_reg};
`endif

  // NOTE: state-holding processes use non-blocking assignments so every register
  // samples pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ACC;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: each combinational output gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ACC:     if (beat_acc && in_last) state_nxt = RESOLVE;
      RESOLVE: state_nxt = OUT;
      OUT:     if (out_ready) state_nxt = ACC;
      default: state_nxt = ACC;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      ACC:     in_ready  = 1'b1;
      OUT:     out_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_reg    <= '0;
      c_reg    <= '0;
      out_data <= '0;
`ifdef CSA_ACC_OVF_EN
      drop     <= 1'b0;
      out_ovf  <= 1'b0;
`endif
    end else begin
      unique case (state)
        ACC: begin
          if (beat_acc) begin
            s_reg <= csa_sum;
            c_reg <= csa_carry;
`ifdef CSA_ACC_OVF_EN
            drop  <= drop | csa_top;
`endif
          end
        end
        RESOLVE: begin
`ifdef CSA_ACC_OVF_EN
          out_data <= res_full[WIDTH-1:0];
          // Any carry lost during accumulation already means the true sum wrapped.
          out_ovf  <= drop | res_full[WIDTH];
`else
          out_data <= s_reg + c_reg;
`endif
        end
        OUT: begin
          if (out_hs) begin
            s_reg <= '0;
            c_reg <= '0;
`ifdef CSA_ACC_OVF_EN
            drop  <= 1'b0;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_csa_accum.sv
// Self-checking bench for csa_accum (WIDTH=32): table-driven packets, directed stall and
// reset sequences, then randomized packets checked against a queue-based scoreboard.
`timescale 1ns/1ps

module tb_csa_accum;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
`ifdef CSA_ACC_OVF_EN
  logic         out_ovf;
`endif

  csa_accum #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef CSA_ACC_OVF_EN
    ,
    .out_ovf   (out_ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] data;
    logic         ovf;
  } exp_t;

  typedef struct {
    int               n;
    logic [3:0][W-1:0] d;
    logic [W-1:0]     exp_data;
    logic             exp_ovf;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[7];
  int   checks = 0;
  int   errors = 0;
  int   sent_n = 0;
  int   got_n  = 0;
  int   out_mode = 0;  // 0: out_ready=1, 1: random, 2: held low

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_vec(input int i, input int n, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] c, input logic [W-1:0] d, input logic [W-1:0] e,
                         input logic o);
    vecs[i].n = n;
    vecs[i].d[0] = a;
    vecs[i].d[1] = b;
    vecs[i].d[2] = c;
    vecs[i].d[3] = d;
    vecs[i].exp_data = e;
    vecs[i].exp_ovf = o;
  endtask

  // Downstream ready generator; changes only just after the rising edge.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (out_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Result monitor: pops the scoreboard on each output handshake, checks hold stability.
  logic         hold;
  logic [W-1:0] hold_data;
  always @(negedge clk) begin
    if (!rst_n) begin
      hold <= 1'b0;
    end else begin
      if (hold) begin
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_data", 64'(out_data), 64'(hold_data));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 64'(exp_q.size()), 64'd1);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("result_data", 64'(out_data), 64'(e.data));
`ifdef CSA_ACC_OVF_EN
          check("result_ovf", 64'(out_ovf), 64'(e.ovf));
`endif
          got_n <= got_n + 1;
        end
      end
      hold      <= out_valid && !out_ready;
      hold_data <= out_data;
    end
  end

  // Present one beat and hold it until accepted; returns just after the accepting edge.
  task automatic send_beat(input logic [W-1:0] d, input logic l);
    int budget;
    budget = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      budget++;
      if (budget > 500) begin
        check("in_ready_timeout", 64'(in_ready), 64'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
  endtask

  task automatic push_exp(input logic [W-1:0] d, input logic o);
    exp_t e;
    e.data = d;
    e.ovf  = o;
    exp_q.push_back(e);
    sent_n++;
  endtask

  task automatic wait_drain();
    int budget;
    budget = 0;
    forever begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
      budget++;
      if (budget > 2000) begin
        check("drain_timeout", 64'(exp_q.size()), 64'd0);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [W-1:0] stall_data;
    logic [63:0]  ref_sum;
    logic [W-1:0] d;
    int           n;

    set_vec(0, 3, 32'd5, 32'd7, 32'd9, 32'd0, 32'd21, 1'b0);
    set_vec(1, 1, 32'hDEADBEEF, 32'd0, 32'd0, 32'd0, 32'hDEADBEEF, 1'b0);
    set_vec(2, 3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'd0, 32'h0, 1'b1);
    set_vec(3, 2, 32'h80000000, 32'h80000000, 32'd0, 32'd0, 32'h0, 1'b1);
    set_vec(4, 4, 32'd1, 32'd2, 32'd3, 32'd4, 32'd10, 1'b0);
    set_vec(5, 2, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 32'h0, 1'b1);
    set_vec(6, 2, 32'h7FFFFFFF, 32'h80000000, 32'd0, 32'd0, 32'hFFFFFFFF, 1'b0);

    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    out_mode = 0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_out_data", 64'(out_data), 64'd0);
`ifdef CSA_ACC_OVF_EN
    check("reset_out_ovf", 64'(out_ovf), 64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Table-driven packets; the first also checks the RESOLVE/OUT timing.
    for (int i = 0; i < 7; i++) begin
      for (int j = 0; j < vecs[i].n; j++) begin
        send_beat(vecs[i].d[j], j == vecs[i].n - 1);
      end
      push_exp(vecs[i].exp_data, vecs[i].exp_ovf);
      if (i == 0) begin
        @(negedge clk);
        check("resolve_out_valid", 64'(out_valid), 64'd0);
        check("resolve_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        check("out_out_valid", 64'(out_valid), 64'd1);
        check("out_in_ready", 64'(in_ready), 64'd0);
      end
      wait_drain();
    end

    // Stalled result with a beat pending upstream: nothing may be accepted.
    out_mode = 2;
    send_beat(32'd5, 1'b0);
    send_beat(32'd6, 1'b1);
    push_exp(32'd11, 1'b0);
    in_valid = 1'b1;
    in_data  = 32'd99;
    in_last  = 1'b1;
    @(negedge clk);
    @(negedge clk);
    stall_data = out_data;
    for (int k = 0; k < 10; k++) begin
      check("stall_in_ready", 64'(in_ready), 64'd0);
      check("stall_out_valid", 64'(out_valid), 64'd1);
      check("stall_out_data", 64'(out_data), 64'd11);
      @(negedge clk);
    end
    check("stall_data_stable", 64'(out_data), 64'(stall_data));
    out_mode = 0;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    wait_drain();
    send_beat(32'd1, 1'b0);
    send_beat(32'd1, 1'b1);
    push_exp(32'd2, 1'b0);
    wait_drain();

    // Asynchronous reset in the middle of a packet.
    send_beat(32'd3, 1'b0);
    send_beat(32'd4, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_out_valid", 64'(out_valid), 64'd0);
    check("midreset_out_data", 64'(out_data), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_beat(32'd10, 1'b1);
    push_exp(32'd10, 1'b0);
    wait_drain();

    // Random packets with input gaps and random downstream backpressure.
    out_mode = 1;
    for (int p = 0; p < 1000; p++) begin
      n = int'($urandom_range(1, 16));
      ref_sum = '0;
      for (int j = 0; j < n; j++) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
        d = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : W'($urandom);
        ref_sum = ref_sum + 64'(d);
        send_beat(d, j == n - 1);
      end
      push_exp(ref_sum[W-1:0], ref_sum >= 64'h1_0000_0000);
    end
    out_mode = 0;
    wait_drain();
    repeat (3) @(posedge clk);
    check("result_count", 64'(got_n), 64'(sent_n));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
